// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch PC register and next-PC sequencer.
// Define PC_DELAY_SLOT_EN for branch-delay-slot sequencing; otherwise redirects are immediate and flushed.
module pc_sequencer #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic             redirect,
    output logic             flush,
    output logic             misalign,
    output logic             bad_slot
);
    logic [WIDTH-1:0] raw, aligned, pc_n;
    logic ev, redirect_n, flush_n, misalign_n, bad_slot_n;
    assign raw = jump_valid ? jump_target : br_target;
    assign aligned = {raw[WIDTH-1:2], 2'b00};
    assign ev = !stall && (jump_valid || (br_valid && br_taken));
`ifdef PC_DELAY_SLOT_EN
    typedef enum logic {SEQ, SLOT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] tgt, tgt_n;
    always_comb begin
        pc_n = pc;
        state_n = state;
        tgt_n = tgt;
        redirect_n = 1'b0;
        flush_n = 1'b0;
        misalign_n = 1'b0;
        bad_slot_n = 1'b0;
        if (!stall && state == SLOT) begin
            pc_n = tgt;
            redirect_n = 1'b1;
            state_n = SEQ;
            bad_slot_n = ev;
        end else if (!stall) begin
            pc_n = pc + WIDTH'(4);
            if (ev) begin
                tgt_n = aligned;
                state_n = SLOT;
                misalign_n = |raw[1:0];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= SEQ;
            tgt <= '0;
        end else begin
            state <= state_n;
            tgt <= tgt_n;
        end
`else
    always_comb begin
        pc_n = stall ? pc : ev ? aligned : pc + WIDTH'(4);
        redirect_n = ev;
        flush_n = ev;
        misalign_n = ev && |raw[1:0];
        bad_slot_n = 1'b0;
    end
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc <= RESET_PC;
            redirect <= 1'b0;
            flush <= 1'b0;
            misalign <= 1'b0;
            bad_slot <= 1'b0;
        end else begin
            pc <= pc_n;
            redirect <= redirect_n;
            flush <= flush_n;
            misalign <= misalign_n;
            bad_slot <= bad_slot_n;
        end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus, per-cycle model compare plus hand-computed literal checks.
// Follows PC_DELAY_SLOT_EN the same way the design does.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, br_valid = 1'b0, br_taken = 1'b0, jump_valid = 1'b0;
    logic [31:0] br_target = '0, jump_target = '0, pc;
    logic redirect, flush, misalign, bad_slot;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .jump_valid(jump_valid), .jump_target(jump_target),
        .pc(pc), .redirect(redirect), .flush(flush), .misalign(misalign), .bad_slot(bad_slot)
    );

    // Model: a pending target means the next unstalled cycle must fetch it.
    logic [31:0] m_pc, m_tgt, t;
    bit m_pend, m_red, m_fl, m_mis, m_bad, acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_tgt = 0; m_pend = 0;
            m_red = 0; m_fl = 0; m_mis = 0; m_bad = 0;
        end else begin
            m_red = 0; m_fl = 0; m_mis = 0; m_bad = 0;
            if (!stall) begin
                acc = jump_valid || (br_valid && br_taken);
                t = jump_valid ? jump_target : br_target;
                if (m_pend) begin
                    m_pc = m_tgt; m_red = 1; m_pend = 0; m_bad = acc;
                end else if (acc) begin
                    m_mis = (t % 4) != 0;
                    m_tgt = t - (t % 4);
                    if (DS) begin
                        m_pc = m_pc + 4; m_pend = 1;
                    end else begin
                        m_pc = m_tgt; m_red = 1; m_fl = 1;
                    end
                end else m_pc = m_pc + 4;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model pc", pc, m_pc);
        chk("model redirect", 32'(redirect), 32'(m_red));
        chk("model flush", 32'(flush), 32'(m_fl));
        chk("model misalign", 32'(misalign), 32'(m_mis));
        chk("model bad_slot", 32'(bad_slot), 32'(m_bad));
    end

    // Apply one cycle of inputs (called at a negedge) and return at the following negedge.
    task automatic cyc(input logic s, input logic bv, input logic bt, input logic [31:0] bta,
                       input logic jv, input logic [31:0] jt);
        stall = s; br_valid = bv; br_taken = bt; br_target = bta; jump_valid = jv; jump_target = jt;
        @(negedge clk);
        stall = 0; br_valid = 0; br_taken = 0; jump_valid = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input logic [31:0] jt);
        cyc(0, 0, 0, 0, 1, jt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk); @(negedge clk);
        chk("reset pc", pc, RST_PC);
        chk("reset pulses", {28'd0, redirect, flush, misalign, bad_slot}, 0);
        rst_n = 1;
        idle(); idle(); idle();
        chk("pc after 3 cycles", pc, 32'h0040_000C);
        if (!DS) begin
            jmp(32'h100);
            chk("jump pc", pc, 32'h100);
            chk("jump redirect/flush", {30'd0, redirect, flush}, 3);
            cyc(0, 1, 0, 32'h200, 0, 0);
            chk("not-taken pc", pc, 32'h104);
            cyc(0, 1, 1, 32'h200, 0, 0);
            chk("taken pc", pc, 32'h200);
            chk("taken redirect/flush", {30'd0, redirect, flush}, 3);
            idle();
            chk("after taken pc", pc, 32'h204);
            chk("after taken pulses", {28'd0, redirect, flush, misalign, bad_slot}, 0);
            cyc(0, 1, 1, 32'h600, 1, 32'h502);
            chk("priority pc", pc, 32'h500);
            chk("priority misalign", 32'(misalign), 1);
            cyc(1, 0, 0, 0, 1, 32'h700);
            chk("stall pc", pc, 32'h500);
            chk("stall pulses", {28'd0, redirect, flush, misalign, bad_slot}, 0);
            jmp(32'hFFFF_FFFC);
            idle();
            chk("wrap pc", pc, 32'h0);
            jmp(32'h900);
        end else begin
            jmp(32'h100);
            chk("slot pc", pc, 32'h0040_0010);
            idle();
            chk("target pc", pc, 32'h100);
            jmp(32'h300);
            chk("ds slot pc", pc, 32'h104);
            chk("ds no flush", 32'(flush), 0);
            cyc(0, 1, 1, 32'h400, 0, 0);
            chk("ds target pc", pc, 32'h300);
            chk("ds redirect", 32'(redirect), 1);
            chk("ds bad_slot", 32'(bad_slot), 1);
            idle();
            chk("ignored branch pc", pc, 32'h304);
            jmp(32'h100);
            idle();
            jmp(32'h800);
            for (int i = 0; i < 4; i++) begin
                cyc(1, 0, 0, 0, 0, 0);
                chk("slot stall pc", pc, 32'h104);
                chk("slot stall pulses", {28'd0, redirect, flush, misalign, bad_slot}, 0);
            end
            idle();
            chk("post-stall pc", pc, 32'h800);
            chk("post-stall redirect", 32'(redirect), 1);
            cyc(0, 1, 1, 32'h600, 1, 32'h502);
            chk("priority misalign", 32'(misalign), 1);
            idle();
            chk("priority pc", pc, 32'h500);
            jmp(32'hFFFF_FFFC);
            idle();
            idle();
            chk("wrap pc", pc, 32'h0);
            jmp(32'h900);
            chk("pre-reset slot pc", pc, 32'h4);
        end
        #2 rst_n = 0;
        #1 chk("async reset pc", pc, RST_PC);
        chk("async reset pulses", {28'd0, redirect, flush, misalign, bad_slot}, 0);
        @(negedge clk);
        rst_n = 1;
        idle();
        chk("pending discarded pc", pc, RST_PC + 32'd4);
        chk("pending discarded redirect", 32'(redirect), 0);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
